// File: rtl/sel_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : sel_decoder_seq
// Description : Registered N-to-2^N one-hot decoder with a built-in sweep
//               sequencer. In normal mode the one-hot decode of sel is
//               registered each cycle. When sweep_req is seen in IDLE, every
//               output row is presented once in ascending order, with busy
//               held high throughout and a one-cycle done pulse at the end.
//
// Ports       : clk       - sole clock, rising edge
//               rst_n     - synchronous active-low reset
//               en        - decode enable (normal mode only)
//               sel       - row index to decode (normal mode only)
//               sweep_req - level-sampled sweep request
//               out       - registered one-hot row select, or all-zero
//               busy      - high while a sweep is in progress
//               done      - single-cycle sweep-completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module sel_decoder_seq #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             sweep_req,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_idx;

    logic [OUT_W-1:0] w_dec;       // normal-mode decode of en/sel
    logic [SEL_W-1:0] w_idx_nxt;   // next sweep row index
    logic [OUT_W-1:0] w_row_nxt;   // one-hot of the next sweep row
    logic             w_last_row;  // sweep currently presenting the top row

    always_comb begin
        w_dec = '0;
        if (en) begin
            w_dec[sel] = 1'b1;
        end
    end

    // The terminal compare is on the all-ones index, so idx+1 never wraps
    // inside a sweep; the wrapped value is only computed, never used.
    assign w_idx_nxt  = r_idx + 1'b1;
    assign w_last_row = (r_idx == '1);

    always_comb begin
        w_row_nxt            = '0;
        w_row_nxt[w_idx_nxt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (sweep_req) begin
                        // Sweep request outranks a simultaneous decode.
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                        out     <= {{(OUT_W-1){1'b0}}, 1'b1};
                        busy    <= 1'b1;
                    end else begin
                        out  <= w_dec;
                        busy <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (w_last_row) begin
                        // Normal decode resumes on the same edge that
                        // closes the sweep, alongside the done pulse.
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        out     <= w_dec;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_idx <= w_idx_nxt;
                        out   <= w_row_nxt;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    out     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sel_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_decoder_seq
// Description : Self-checking bench for sel_decoder_seq at SEL_W = 1, 3, 5.
//               All three instances share one stimulus stream; a
//               row-countdown model predicts every output each cycle, and
//               directed literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_decoder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [4:0]  sel;
    logic        sweep_req;

    logic [1:0]  o1;
    logic [7:0]  o3;
    logic [31:0] o5;
    logic        b1, b3, b5, d1, d3, d5;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    sel_decoder_seq #(.SEL_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[0:0]),
        .sweep_req(sweep_req), .out(o1), .busy(b1), .done(d1)
    );
    sel_decoder_seq #(.SEL_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[2:0]),
        .sweep_req(sweep_req), .out(o3), .busy(b3), .done(d3)
    );
    sel_decoder_seq #(.SEL_W(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
        .sweep_req(sweep_req), .out(o5), .busy(b5), .done(d5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Model: each instance tracks how many busy cycles of its sweep are
    // left (0 = not sweeping). Outputs follow from that count.
    // ------------------------------------------------------------------
    int          m_n    [3] = '{2, 8, 32};
    int          m_left [3];
    logic [31:0] m_out  [3];
    logic        m_done [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] dec;
            dec = en ? (32'd1 << (int'(sel) % m_n[i])) : 32'd0;
            if (!rst_n) begin
                m_left[i] = 0;
                m_out[i]  = '0;
                m_done[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_out[i]  = dec;
                    m_done[i] = 1'b1;
                end else begin
                    m_out[i]  = m_out[i] << 1;
                    m_done[i] = 1'b0;
                end
            end else if (sweep_req) begin
                m_left[i] = m_n[i];
                m_out[i]  = 32'd1;
                m_done[i] = 1'b0;
            end else begin
                m_out[i]  = dec;
                m_done[i] = 1'b0;
            end
        end
    end

    function automatic bit onehot0(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] a_out [3];
            logic        a_busy[3];
            logic        a_done[3];
            a_out[0] = {30'd0, o1}; a_busy[0] = b1; a_done[0] = d1;
            a_out[1] = {24'd0, o3}; a_busy[1] = b3; a_done[1] = d3;
            a_out[2] = o5;          a_busy[2] = b5; a_done[2] = d5;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_out[w%0d]", m_n[i]), a_out[i], m_out[i]);
                chk($sformatf("model_busy_done[w%0d]", m_n[i]),
                    {30'd0, a_busy[i], a_done[i]},
                    {30'd0, (m_left[i] > 0), m_done[i]});
                chk($sformatf("invariant[w%0d]", m_n[i]),
                    {31'd0, onehot0(a_out[i]) && !(a_busy[i] && a_out[i] == 32'd0)},
                    32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] rows [8];
    int cnt_b, cnt_d, cnt_b5;

    initial begin
        rows = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rst_n = 1'b0; en = 1'b0; sel = '0; sweep_req = 1'b0;
        cyc(); cyc();
        chk("reset_out3", {24'd0, o3}, 32'h0);
        chk("reset_out5", o5, 32'h0);
        chk("reset_busy_done", {30'd0, b3, d3}, 32'h0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Normal decode
        en = 1'b1; sel = 5'd5; cyc();
        chk("dec_sel5", {24'd0, o3}, 32'h20);
        en = 1'b0; cyc();
        chk("dec_en0", {24'd0, o3}, 32'h00);
        en = 1'b1; sel = 5'd0; cyc();
        chk("dec_sel0", {24'd0, o3}, 32'h01);
        sel = 5'd7; cyc();
        chk("dec_sel7", {24'd0, o3}, 32'h80);
        sel = 5'd31; cyc();
        chk("dec_w5_sel31", o5, 32'h8000_0000);
        chk("dec_w1_sel1", {30'd0, o1}, 32'h2);

        // Full sweep from a single-cycle request
        sel = 5'd3; sweep_req = 1'b1; cyc(); sweep_req = 1'b0;
        chk("sweep_row0", {23'd0, b3, o3}, {23'd0, 1'b1, rows[0]});
        for (int r = 1; r < 8; r++) begin
            cyc();
            chk($sformatf("sweep_row%0d", r), {23'd0, b3, o3}, {23'd0, 1'b1, rows[r]});
        end
        cyc();
        chk("sweep_end", {22'd0, b3, d3, o3}, {22'd0, 1'b0, 1'b1, 8'h08});
        cyc();
        chk("sweep_done_drop", {31'd0, d3}, 32'd0);
        repeat (30) cyc();

        // Priority over decode, then inputs toggling mid-sweep
        en = 1'b1; sel = 5'd6; sweep_req = 1'b1; cyc();
        chk("prio_row0", {24'd0, o3}, 32'h01);
        cnt_d = 0;
        for (int i = 0; i < 7; i++) begin
            sweep_req = ~sweep_req; sel = 5'(i * 3); cyc();
            cnt_d += int'(d3);
        end
        sweep_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); cnt_d += int'(d3);
        end
        chk("toggle_one_done", cnt_d, 1);
        repeat (30) cyc();

        // Reset mid-sweep
        en = 1'b0; sweep_req = 1'b1; cyc(); sweep_req = 1'b0;
        cyc(); cyc(); cyc();
        chk("abort_at_row3", {24'd0, o3}, 32'h08);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("abort_cleared", {22'd0, b3, d3, o3}, 32'h0);
        cnt_d = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); cnt_d += int'(d3);
        end
        chk("abort_no_done", cnt_d, 0);
        sweep_req = 1'b1; cyc(); sweep_req = 1'b0;
        chk("restart_row0", {24'd0, o3}, 32'h01);
        repeat (40) cyc();

        // Held request: two full sweeps plus two rows of a third
        cnt_b = 0; cnt_d = 0;
        sweep_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(); cnt_b += int'(b3); cnt_d += int'(d3);
        end
        sweep_req = 1'b0;
        chk("held_third_row1", {24'd0, o3}, 32'h02);
        chk("held_busy_window", cnt_b, 18);
        for (int i = 0; i < 30; i++) begin
            cyc(); cnt_b += int'(b3); cnt_d += int'(d3);
        end
        chk("held_busy_total", cnt_b, 24);
        chk("held_done_total", cnt_d, 3);
        repeat (20) cyc();

        // Narrow and wide instances
        en = 1'b0; sweep_req = 1'b1; cyc(); sweep_req = 1'b0;
        cnt_b5 = int'(b5);
        chk("w1_row0", {30'd0, o1}, 32'h1);
        cyc(); cnt_b5 += int'(b5);
        chk("w1_row1", {29'd0, b1, o1}, 32'h6);
        cyc(); cnt_b5 += int'(b5);
        chk("w1_done", {29'd0, d1, o1}, 32'h4);
        for (int i = 0; i < 40; i++) begin
            cyc(); cnt_b5 += int'(b5);
        end
        chk("w5_busy_len", cnt_b5, 32);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sel_decoder_seq.md
# sel_decoder_seq

Registered, parametrised N-to-2^N one-hot decoder with a built-in sweep sequencer. It drives row/write-enable selects for the register file and other indexed storage in the single-cycle datapath. In normal mode it registers the one-hot decode of `sel`. On request it walks every output row once in ascending order, for bulk clear or initialisation, with a busy/done handshake.

## Interface
- `SEL_W`, default 3: select width, legal range 1..8. Output width `OUT_W` = 2^SEL_W is derived and not overridable.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  decode enable, normal mode only.
- `sel`  in  SEL_W  row index to decode, normal mode only.
- `sweep_req`  in  1  level-sampled request to start a full-row sweep.
- `out`  out  OUT_W  registered one-hot row select, or all-zero.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  single-cycle pulse marking sweep completion.

## Operation
- States: IDLE, SWEEP. Internal index counter `idx` is SEL_W bits wide.
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, idx=0.
  - `out`=0, `busy`=0, `done`=0.
- IDLE, `sweep_req`=0:
  - `out` <= `en` ? (1 << `sel`) : 0.
  - `busy` <= 0, `done` <= 0.
- IDLE, `sweep_req`=1:
  - state <= SWEEP, idx <= 0.
  - `out` <= 1 (row 0), `busy` <= 1, `done` <= 0.
  - `sweep_req` has priority over `en`/`sel` when both are asserted.
- SWEEP, idx != OUT_W-1:
  - idx <= idx+1, `out` <= 1 << (idx+1), `busy` stays 1.
- SWEEP, idx == OUT_W-1, the terminal row:
  - state <= IDLE, idx <= 0.
  - `busy` <= 0, `done` <= 1.
  - `out` <= `en` ? (1 << `sel`) : 0, i.e. normal decode resumes on this same edge.
- In SWEEP, `en`, `sel` and `sweep_req` are ignored. A request raised mid-sweep is neither queued nor extended.
- `done` is high for exactly one cycle, then falls at the next edge unless reset intervenes.
- Invariant: `out` is always zero or exactly one-hot. `busy`=1 implies `out` != 0.
- Reset mid-sweep aborts immediately: no `done` pulse, and `out`=0 on the next cycle.
- idx never wraps past OUT_W-1 inside a sweep. The terminal compare is on the all-ones value.

## Timing
- Normal decode latency: 1 cycle from `en`/`sel` sampled at edge k to `out` valid after edge k.
- Sweep length:
  - `busy` is high for exactly OUT_W consecutive cycles (8 at SEL_W=3).
  - Row r is presented in the r-th busy cycle, counting from 0.
- Sweep start: request sampled at edge k, so `out`=row 0 and `busy`=1 after edge k.
- Sweep end: `done`=1 after edge k+OUT_W, coincident with `busy`=0.
- Back-to-back sweeps:
  - `sweep_req` held high is first re-sampled at edge k+OUT_W+1, which starts the next sweep.
  - Minimum gap is one non-busy cycle, the `done` cycle.
- All outputs are registers. There is no combinational input-to-output path.

## Test plan
- Normal decode, SEL_W=3:
  - `en`=1, `sel`=5 -> `out`=8'h20 one cycle later.
  - `en`=0 -> `out`=8'h00.
  - `sel`=0 then 7 -> `out`=8'h01 then 8'h80.
- Full sweep, SEL_W=3, 1-cycle `sweep_req` pulse:
  - `out` steps 01,02,04,08,10,20,40,80 with `busy`=1 for 8 cycles.
  - Next cycle: `busy`=0, `done`=1, `out`=decode of current `en`/`sel`.
  - Following cycle: `done`=0.
- Priority/ignore:
  - `sweep_req`=1 with `en`=1, `sel`=6 in IDLE -> `out`=8'h01 (not 8'h40).
  - `sweep_req` and `sel` toggling during SWEEP -> sequence unchanged, exactly one `done`.
- Reset mid-sweep:
  - `rst_n`=0 while `out`=8'h08 -> next cycle `out`=0, `busy`=0, `done`=0.
  - No `done` pulse afterward.
  - A new request after release starts again at row 0.
- Held request:
  - `sweep_req` tied high for 20 cycles -> busy 8, done 1, busy 8, done 1, busy 2 (`sweep_req` deasserted here, partway through the third sweep).
  - The third sweep runs to completion: rows 02..80, then `done`.
- Parametrisation:
  - SEL_W=1: sweep gives 2'b01, 2'b10, then `done`.
  - SEL_W=5: `sel`=31, `en`=1 -> only `out`[31] set.
  - SEL_W=5 sweep -> `busy` high exactly 32 cycles.
